// File: rtl/div_pkg.sv
// Shared FSM encoding and default operand width for the sequential unsigned divider.
package div_pkg;

    localparam int DIV_WIDTH_DEFAULT = 8;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_CALC = 2'd1,
        ST_DONE = 2'd2
    } div_state_t;

endpackage

// File: rtl/div_trial_sub.sv
// Combinational trial subtraction for one restoring-division step.
module div_trial_sub #(
    parameter int W = 9
) (
    input  logic [W-1:0] minuend,
    input  logic [W-1:0] subtrahend,
    output logic [W-1:0] diff,
    output logic         non_neg
);

    logic borrow;

    assign {borrow, diff} = {1'b0, minuend} - {1'b0, subtrahend};
    assign non_neg        = ~borrow;

endmodule

// File: rtl/seq_unsigned_divider.sv
// Sequential restoring divider: one quotient bit per clock, MSB first.
//   state   | meaning
//   IDLE    | ready for a new operation, results held
//   CALC    | iterating, one quotient bit per edge
//   DONE    | one-cycle done pulse, results valid
module seq_unsigned_divider
    import div_pkg::*;
#(
    parameter int WIDTH = DIV_WIDTH_DEFAULT
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic             ready,
    output logic             done,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder,
    output logic             div_by_zero
);

    localparam int CW = $clog2(WIDTH);

    div_state_t       state;
    div_state_t       state_next;
    logic [CW-1:0]    cnt;
    logic [WIDTH-1:0] dvs_q;
    logic [WIDTH-1:0] acc_q;
    logic [WIDTH-1:0] rem_q;
    logic             accept;
    logic [WIDTH:0]   shifted;
    logic [WIDTH:0]   diff;
    logic             non_neg;
    logic [WIDTH-1:0] rem_next;
    logic [WIDTH-1:0] acc_next;

    assign accept  = start && (state == ST_IDLE);
    assign shifted = {rem_q, acc_q[WIDTH-1]};

    div_trial_sub #(
        .W (WIDTH + 1)
    ) u_trial_sub (
        .minuend    (shifted),
        .subtrahend ({1'b0, dvs_q}),
        .diff       (diff),
        .non_neg    (non_neg)
    );

    // Partial remainder stays below the divisor, so the difference MSB is zero whenever it is kept.
    wire unused_diff_msb = diff[WIDTH];

    assign rem_next = non_neg ? diff[WIDTH-1:0] : shifted[WIDTH-1:0];
    assign acc_next = {acc_q[WIDTH-2:0], non_neg};

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        ready      = 1'b0;
        done       = 1'b0;
        case (state)
            ST_IDLE: begin
                ready = 1'b1;
                if (start) begin
                    state_next = (divisor == '0) ? ST_DONE : ST_CALC;
                end
            end
            ST_CALC: begin
                if (cnt == '0) begin
                    state_next = ST_DONE;
                end
            end
            ST_DONE: begin
                done       = 1'b1;
                state_next = ST_IDLE;
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

    // Dividend register doubles as the quotient shift register; results latch on the last iteration.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt         <= '0;
            dvs_q       <= '0;
            acc_q       <= '0;
            rem_q       <= '0;
            quotient    <= '0;
            remainder   <= '0;
            div_by_zero <= 1'b0;
        end else if (accept) begin
            dvs_q <= divisor;
            acc_q <= dividend;
            rem_q <= '0;
            cnt   <= CW'(WIDTH - 1);
            if (divisor == '0) begin
                quotient    <= '1;
                remainder   <= dividend;
                div_by_zero <= 1'b1;
            end
        end else if (state == ST_CALC) begin
            acc_q <= acc_next;
            rem_q <= rem_next;
            cnt   <= cnt - CW'(1);
            if (cnt == '0) begin
                quotient    <= acc_next;
                remainder   <= rem_next;
                div_by_zero <= 1'b0;
            end
        end
    end

endmodule

// File: doc/seq_unsigned_divider.md
SEQ_UNSIGNED_DIVIDER -- requirements
Module: seq_unsigned_divider

Interface
REQ-001 Parameter: WIDTH, default 8, operand/result bit width (legal 4..16).
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst_n  input  1  synchronous, active-low reset, sampled on rising edge of clk.
REQ-004 start  input  1  request new division; sampled only when ready=1.
REQ-005 dividend  input  WIDTH  unsigned numerator, captured on accepted start.
REQ-006 divisor  input  WIDTH  unsigned denominator, captured on accepted start.
REQ-007 ready  output  1  high only in IDLE; start accepted when start=1 and ready=1.
REQ-008 done  output  1  one-cycle pulse; results valid in that cycle.
REQ-009 quotient  output  WIDTH  unsigned floor(dividend/divisor).
REQ-010 remainder  output  WIDTH  unsigned dividend mod divisor.
REQ-011 div_by_zero  output  1  high with done when captured divisor was 0.

Function
REQ-012 The block SHALL implement a three-state FSM: IDLE, CALC, DONE.
REQ-013 IDLE -> CALC on accepted start with nonzero divisor; IDLE -> DONE on accepted start with zero divisor.
REQ-014 In CALC the block SHALL perform one restoring-division iteration per edge, MSB first: shift {partial remainder, dividend} left by 1, trial-subtract divisor from (WIDTH+1)-bit partial remainder, keep difference and set quotient bit to 1 if non-negative, else restore and set 0.
REQ-015 Trial subtraction SHALL be WIDTH+1 bits wide so no intermediate overflow occurs.
REQ-016 An iteration counter SHALL count WIDTH iterations; on the WIDTH-th iteration edge the FSM SHALL go CALC -> DONE.
REQ-017 done SHALL be high for exactly one cycle (state DONE), then FSM returns to IDLE unconditionally.
REQ-018 Latency: for nonzero divisor, done SHALL be high in the cycle following the (WIDTH+1)-th rising edge counted from and including the edge that accepted start; for zero divisor, in the cycle following that edge.
REQ-019 Divide by zero SHALL yield quotient = all ones, remainder = captured dividend, div_by_zero = 1.
REQ-020 quotient, remainder, div_by_zero SHALL hold their values from DONE until the next accepted start.
REQ-021 start while ready=0 (CALC, DONE) SHALL be ignored; inputs changing during CALC SHALL not affect the result.
REQ-022 Dividend < divisor SHALL give quotient 0, remainder = dividend; dividend 0 SHALL give 0, 0.

Reset
REQ-023 With rst_n=0 at an edge: state=IDLE, counter=0, ready=1 after reset, done=0, quotient=0, remainder=0, div_by_zero=0.
REQ-024 Reset asserted mid-CALC or in DONE SHALL abort the operation with no done pulse; reset SHALL take priority over start in the same edge.

Structure
REQ-025 A shared package div_pkg SHALL hold the FSM state encoding (IDLE, CALC, DONE) and the WIDTH default constant.
REQ-026 One sub-module, div_trial_sub, SHALL implement the (WIDTH+1)-bit trial subtraction (difference and borrow/non-negative flag), combinational.

Verification
REQ-027 WIDTH=8, 100/7 -> quotient 14, remainder 2, div_by_zero 0, done exactly 9 edges after accepting edge inclusive.
REQ-028 255/1 -> 255, 0; 255/255 -> 1, 0; 5/9 -> 0, 5; 0/3 -> 0, 0.
REQ-029 37/0 -> done in cycle after accepting edge, quotient 255, remainder 37, div_by_zero 1.
REQ-030 Start 200/3, then pulse start with 9/2 and change operands during CALC -> result 66, 2; second start ignored, single done pulse.
REQ-031 Start 100/7, assert rst_n=0 at 4th CALC edge -> no done, outputs 0, ready 1; then 50/6 -> 8, 2.
REQ-032 Back-to-back: start asserted in the cycle after done -> accepted, correct second result; random 10k operand pairs checked against reference model.
